// File: rtl/pwm_level_sequencer.sv
// Configuration sequencer for one PWM level cell: shadows host config words, applies them at
// carrier valleys, and slew-limits the compare value so retuning never yields a runt pulse.
module pwm_level_sequencer #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned RAMP_STEP = 8,
  parameter int unsigned DEF_MAX   = 500,
  parameter int unsigned DEF_STEP  = 1,
  parameter int unsigned DEF_DEAD  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             period_sync,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_compare,
  input  logic [WIDTH-1:0] cfg_max_count,
  input  logic [WIDTH-1:0] cfg_step_size,
  input  logic [WIDTH-1:0] cfg_dead_time,
  output logic             cfg_err,
  output logic [WIDTH-1:0] compare,
  output logic [WIDTH-1:0] pwm_max_count,
  output logic [WIDTH-1:0] triangle_step_size,
  output logic [WIDTH-1:0] dead_time_count,
  output logic             level_en,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ARM, RAMP, RUN} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] cmp;
    logic [WIDTH-1:0] max;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] dead;
  } cfg_t;

  state_t           state;
  cfg_t             shadow;
  logic             pending;
  logic [WIDTH-1:0] target;

  logic             accept_c;
  logic             cfg_bad_c;
  logic             apply_c;
  logic [WIDTH-1:0] target_new_c;
  logic [WIDTH-1:0] target_eff_c;
  logic [WIDTH:0]   diff_c;
  logic [WIDTH:0]   mag_c;
  logic [WIDTH:0]   step_c;
  logic [WIDTH-1:0] ramp_next_c;

  // Handshake, apply decision and one slew-limited step toward the effective target.
  always_comb begin
    accept_c     = cfg_valid && cfg_ready;
    cfg_bad_c    = (cfg_max_count == '0) || (cfg_step_size == '0);
    apply_c      = enable && period_sync && pending && (state != IDLE);
    target_new_c = (shadow.cmp > shadow.max) ? shadow.max : shadow.cmp;
    target_eff_c = apply_c ? target_new_c : target;
    diff_c       = {1'b0, target_eff_c} - {1'b0, compare};
    mag_c        = diff_c[WIDTH] ? (~diff_c + (WIDTH+1)'(1)) : diff_c;
    step_c       = (mag_c > (WIDTH+1)'(RAMP_STEP)) ? (WIDTH+1)'(RAMP_STEP) : mag_c;
    ramp_next_c  = diff_c[WIDTH] ? (compare - WIDTH'(step_c)) : (compare + WIDTH'(step_c));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      shadow             <= '0;
      pending            <= 1'b0;
      target             <= '0;
      cfg_ready          <= 1'b1;
      cfg_err            <= 1'b0;
      compare            <= '0;
      pwm_max_count      <= WIDTH'(DEF_MAX);
      triangle_step_size <= WIDTH'(DEF_STEP);
      dead_time_count    <= WIDTH'(DEF_DEAD);
      level_en           <= 1'b0;
      busy               <= 1'b0;
    end else begin
      cfg_err <= 1'b0;

      // Invalid words complete the handshake but never reach the shadow.
      if (accept_c) begin
        if (cfg_bad_c) begin
          cfg_err <= 1'b1;
        end else begin
          shadow    <= '{cmp: cfg_compare, max: cfg_max_count,
                         step: cfg_step_size, dead: cfg_dead_time};
          pending   <= 1'b1;
          cfg_ready <= 1'b0;
        end
      end

      if (apply_c) begin
        pwm_max_count      <= shadow.max;
        triangle_step_size <= shadow.step;
        dead_time_count    <= shadow.dead;
        target             <= target_new_c;
        pending            <= 1'b0;
        cfg_ready          <= 1'b1;
      end

      if (!enable) begin
        state    <= IDLE;
        level_en <= 1'b0;
        compare  <= '0;
        busy     <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            level_en <= 1'b0;
            compare  <= '0;
            state    <= ARM;
            busy     <= 1'b1;
          end
          ARM: begin
            if (period_sync) begin
              level_en <= 1'b1;
              if (compare != target_eff_c) begin
                state <= RAMP;
                busy  <= 1'b1;
              end else begin
                state <= RUN;
                busy  <= 1'b0;
              end
            end
          end
          RAMP: begin
            if (period_sync) begin
              compare <= ramp_next_c;
              if (ramp_next_c == target_eff_c) begin
                state <= RUN;
                busy  <= 1'b0;
              end
            end
          end
          RUN: begin
            // A retarget only arms the ramp; compare first moves on the following valley.
            if (apply_c && (target_new_c != compare)) begin
              state <= RAMP;
              busy  <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_level_sequencer.sv
// Bench for pwm_level_sequencer: directed scenarios plus a randomized run, all checked against a
// valley-by-valley behavioural model of the sequencer.
module tb_pwm_level_sequencer;

  localparam int unsigned WIDTH = 16;
  localparam int RAMP = 8;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic             period_sync;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_compare;
  logic [WIDTH-1:0] cfg_max_count;
  logic [WIDTH-1:0] cfg_step_size;
  logic [WIDTH-1:0] cfg_dead_time;
  logic             cfg_err;
  logic [WIDTH-1:0] compare;
  logic [WIDTH-1:0] pwm_max_count;
  logic [WIDTH-1:0] triangle_step_size;
  logic [WIDTH-1:0] dead_time_count;
  logic             level_en;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  pwm_level_sequencer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .period_sync(period_sync),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_compare(cfg_compare),
    .cfg_max_count(cfg_max_count), .cfg_step_size(cfg_step_size),
    .cfg_dead_time(cfg_dead_time), .cfg_err(cfg_err), .compare(compare),
    .pwm_max_count(pwm_max_count), .triangle_step_size(triangle_step_size),
    .dead_time_count(dead_time_count), .level_en(level_en), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: phase 0 = off, 1 = waiting for first valley, 2 = running.
  int m_phase, m_cmp, m_tgt, m_max, m_step, m_dead, m_move;
  int s_cmp, s_max, s_step, s_dead;
  bit m_en, m_pending, m_err, m_take, m_apply, m_settled;
  logic m_busy;
  assign m_busy = (m_phase == 1) || (m_phase == 2 && m_cmp != m_tgt);

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0; m_cmp = 0; m_tgt = 0; m_max = 500; m_step = 1; m_dead = 5;
      m_en = 0; m_pending = 0; m_err = 0;
      s_cmp = 0; s_max = 0; s_step = 0; s_dead = 0;
    end else begin
      m_settled = (m_cmp == m_tgt);
      m_take    = cfg_valid && !m_pending;
      m_apply   = enable && period_sync && m_pending && (m_phase != 0);
      m_err     = m_take && (cfg_max_count == 0 || cfg_step_size == 0);
      if (m_apply) begin
        m_max = s_max; m_step = s_step; m_dead = s_dead;
        m_tgt = (s_cmp < s_max) ? s_cmp : s_max;
        m_pending = 0;
      end
      if (m_take && !m_err) begin
        s_cmp = int'(cfg_compare); s_max = int'(cfg_max_count);
        s_step = int'(cfg_step_size); s_dead = int'(cfg_dead_time);
        m_pending = 1;
      end
      if (!enable) begin
        m_phase = 0; m_en = 0; m_cmp = 0;
      end else if (m_phase == 0) begin
        m_phase = 1;
      end else if (period_sync) begin
        if (m_phase == 1) begin
          m_phase = 2; m_en = 1;
        end else if (!m_settled) begin
          m_move = m_tgt - m_cmp;
          if (m_move > RAMP) m_move = RAMP;
          if (m_move < -RAMP) m_move = -RAMP;
          m_cmp = m_cmp + m_move;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_sync();
    period_sync = 1'b1;
    tick();
    period_sync = 1'b0;
  endtask

  task automatic send_word(input int c, input int m, input int s, input int d);
    cfg_valid = 1'b1;
    cfg_compare = WIDTH'(c); cfg_max_count = WIDTH'(m);
    cfg_step_size = WIDTH'(s); cfg_dead_time = WIDTH'(d);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (compare !== 16'd0 || level_en !== 1'b0 || busy !== 1'b0 || cfg_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ctl: compare=%0d level_en=%0b busy=%0b err=%0b, need 0/0/0/0",
               compare, level_en, busy, cfg_err);
    end
    n_checks++;
    if (pwm_max_count !== 16'd500 || triangle_step_size !== 16'd1 ||
        dead_time_count !== 16'd5 || cfg_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_cfg: max=%0d step=%0d dead=%0d ready=%0b, need 500/1/5/1",
               pwm_max_count, triangle_step_size, dead_time_count, cfg_ready);
    end
  endtask

  task automatic test_ramp_up();
    int exp_c;
    enable = 1'b1;
    idle(2);
    send_word(300, 500, 2, 5);
    idle(2);
    for (int k = 0; k < 42; k++) begin
      send_sync();
      exp_c = (k * 8 > 300) ? 300 : k * 8;
      n_checks++;
      if (compare !== WIDTH'(exp_c) || level_en !== 1'b1 || busy !== m_busy) begin
        n_errors++;
        $display("FAIL ramp_up sync %0d: compare=%0d en=%0b busy=%0b, need %0d/1/%0b",
                 k, compare, level_en, busy, exp_c, m_busy);
      end
      idle(3);
    end
    n_checks++;
    if (busy !== 1'b0 || triangle_step_size !== 16'd2 || cfg_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL ramp_up_end: busy=%0b step=%0d ready=%0b, need 0/2/1",
               busy, triangle_step_size, cfg_ready);
    end
  endtask

  task automatic test_ramp_down();
    int exp_c;
    send_word(150, 500, 2, 5);
    idle(2);
    for (int j = 0; j < 21; j++) begin
      send_sync();
      exp_c = (300 - 8 * j < 150) ? 150 : 300 - 8 * j;
      n_checks++;
      if (compare !== WIDTH'(exp_c) || pwm_max_count !== 16'd500 ||
          triangle_step_size !== 16'd2 || dead_time_count !== 16'd5) begin
        n_errors++;
        $display("FAIL ramp_down sync %0d: compare=%0d max=%0d step=%0d dead=%0d, need %0d/500/2/5",
                 j, compare, pwm_max_count, triangle_step_size, dead_time_count, exp_c);
      end
      idle(2);
    end
  endtask

  task automatic test_clamp();
    int exp_c;
    send_word(600, 500, 2, 5);
    idle(2);
    for (int j = 0; j < 47; j++) begin
      send_sync();
      exp_c = (150 + 8 * j > 500) ? 500 : 150 + 8 * j;
      n_checks++;
      if (compare !== WIDTH'(exp_c) || compare > 16'd500) begin
        n_errors++;
        $display("FAIL clamp sync %0d: compare=%0d, need %0d", j, compare, exp_c);
      end
      idle(2);
    end
    n_checks++;
    if (compare !== 16'd500 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL clamp_end: compare=%0d busy=%0b, need 500/0", compare, busy);
    end
  endtask

  task automatic test_bad_word();
    send_word(123, 500, 0, 7);
    n_checks++;
    if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bad_word_err: err=%0b ready=%0b, need 1/1", cfg_err, cfg_ready);
    end
    tick();
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_errors++;
      $display("FAIL bad_word_pulse: err=%0b, need 0", cfg_err);
    end
    send_sync();
    n_checks++;
    if (compare !== 16'd500 || triangle_step_size !== 16'd2 || dead_time_count !== 16'd5) begin
      n_errors++;
      $display("FAIL bad_word_hold: compare=%0d step=%0d dead=%0d, need 500/2/5",
               compare, triangle_step_size, dead_time_count);
    end
  endtask

  task automatic test_coincident();
    period_sync = 1'b1;
    send_word(400, 500, 3, 9);
    period_sync = 1'b0;
    n_checks++;
    if (triangle_step_size !== 16'd2 || dead_time_count !== 16'd5 || cfg_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL coinc_same: step=%0d dead=%0d ready=%0b, need 2/5/0",
               triangle_step_size, dead_time_count, cfg_ready);
    end
    idle(3);
    n_checks++;
    if (cfg_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL coinc_ready: ready=%0b, need 0", cfg_ready);
    end
    send_sync();
    n_checks++;
    if (triangle_step_size !== 16'd3 || dead_time_count !== 16'd9 || compare !== 16'd500 ||
        cfg_ready !== 1'b1 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL coinc_apply: step=%0d dead=%0d compare=%0d ready=%0b busy=%0b, need 3/9/500/1/1",
               triangle_step_size, dead_time_count, compare, cfg_ready, busy);
    end
    idle(2);
    send_sync();
    n_checks++;
    if (compare !== 16'd492) begin
      n_errors++;
      $display("FAIL coinc_step: compare=%0d, need 492", compare);
    end
  endtask

  task automatic test_enable_and_reset();
    idle(2);
    send_sync();
    enable = 1'b0;
    tick();
    n_checks++;
    if (level_en !== 1'b0 || compare !== 16'd0 || triangle_step_size !== 16'd3 ||
        dead_time_count !== 16'd9 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL disable: en=%0b compare=%0d step=%0d dead=%0d busy=%0b, need 0/0/3/9/0",
               level_en, compare, triangle_step_size, dead_time_count, busy);
    end
    send_word(200, 500, 4, 6);
    enable = 1'b1;
    idle(2);
    send_sync();
    n_checks++;
    if (level_en !== 1'b1 || compare !== 16'd0 || triangle_step_size !== 16'd4 ||
        dead_time_count !== 16'd6) begin
      n_errors++;
      $display("FAIL reenable: en=%0b compare=%0d step=%0d dead=%0d, need 1/0/4/6",
               level_en, compare, triangle_step_size, dead_time_count);
    end
    send_sync();
    send_sync();
    n_checks++;
    if (compare !== 16'd16) begin
      n_errors++;
      $display("FAIL reenable_ramp: compare=%0d, need 16", compare);
    end
    send_word(250, 400, 7, 8);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (compare !== 16'd0 || level_en !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 ||
        pwm_max_count !== 16'd500 || triangle_step_size !== 16'd1 || dead_time_count !== 16'd5) begin
      n_errors++;
      $display("FAIL async_reset: compare=%0d en=%0b busy=%0b ready=%0b max=%0d step=%0d dead=%0d",
               compare, level_en, busy, cfg_ready, pwm_max_count, triangle_step_size,
               dead_time_count);
    end
    idle(2);
    rst_n = 1'b1;
    idle(3);
    send_sync();
    n_checks++;
    if (level_en !== 1'b1 || compare !== 16'd0 || triangle_step_size !== 16'd1 ||
        pwm_max_count !== 16'd500 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL shadow_dropped: en=%0b compare=%0d step=%0d max=%0d busy=%0b, need 1/0/1/500/0",
               level_en, compare, triangle_step_size, pwm_max_count, busy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      period_sync   = ($urandom_range(0, 9) == 0);
      cfg_valid     = ($urandom_range(0, 5) == 0);
      cfg_compare   = WIDTH'($urandom_range(0, 700));
      cfg_max_count = ($urandom_range(0, 7) == 0) ? 16'd0 : WIDTH'($urandom_range(1, 600));
      cfg_step_size = ($urandom_range(0, 7) == 0) ? 16'd0 : WIDTH'($urandom_range(1, 20));
      cfg_dead_time = WIDTH'($urandom_range(0, 50));
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      tick();
      n_checks++;
      if (compare !== WIDTH'(m_cmp) || level_en !== m_en || busy !== m_busy ||
          cfg_ready !== !m_pending || cfg_err !== m_err || pwm_max_count !== WIDTH'(m_max) ||
          triangle_step_size !== WIDTH'(m_step) || dead_time_count !== WIDTH'(m_dead)) begin
        n_errors++;
        $display("FAIL random cyc %0d: cmp=%0d/%0d en=%0b/%0b busy=%0b/%0b rdy=%0b/%0b err=%0b/%0b max=%0d/%0d step=%0d/%0d dead=%0d/%0d",
                 i, compare, m_cmp, level_en, m_en, busy, m_busy, cfg_ready, !m_pending,
                 cfg_err, m_err, pwm_max_count, m_max, triangle_step_size, m_step,
                 dead_time_count, m_dead);
      end
    end
    period_sync = 1'b0;
    cfg_valid   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; period_sync = 1'b0; cfg_valid = 1'b0;
    cfg_compare = '0; cfg_max_count = '0; cfg_step_size = '0; cfg_dead_time = '0;
    idle(3);
    test_reset();
    rst_n = 1'b1;
    idle(2);
    test_ramp_up();
    test_ramp_down();
    test_clamp();
    test_bad_word();
    test_coincident();
    test_enable_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
